// File: rtl/queue_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : queue_wr_arbiter_pkg
// Description : Shared types for the queue write-side arbiter: the queue word
//               type and the arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package queue_wr_arbiter_pkg;

    localparam int c_DATA_W = 16;

    // Word type carried by the queue push port.
    typedef logic [c_DATA_W-1:0] data_t;

    // Arbiter state: no grant held / grant held.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage : queue_wr_arbiter_pkg
`default_nettype wire

// File: rtl/queue_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : queue_wr_arbiter_rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request at or after i_start, wrapping around, using a
//               double-width rotate followed by a priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module queue_wr_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_start,
    output logic               o_found,
    output logic [IDW-1:0]     o_idx
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDW-1:0]       w_off;
    logic [IDW:0]         w_sum;

    // Rotating the doubled vector right puts request i_start at bit 0.
    assign w_dbl = {i_req, i_req};
    assign w_rot = NUM_REQ'(w_dbl >> i_start);

    // Priority encode the rotated vector: lowest set bit is the closest
    // requester to i_start.
    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end
    end

    assign o_found = |i_req;

    // Undo the rotation: winner = (start + offset) mod NUM_REQ. The sum never
    // exceeds 2*NUM_REQ-2, so a single conditional subtract suffices.
    assign w_sum = {1'b0, i_start} + {1'b0, w_off};
    assign o_idx = (w_sum >= (IDW+1)'(NUM_REQ)) ? IDW'(w_sum - (IDW+1)'(NUM_REQ))
                                                : w_sum[IDW-1:0];

endmodule : queue_wr_arbiter_rr_pick
`default_nettype wire

// File: rtl/queue_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : queue_wr_arbiter
// Description : Round-robin arbiter sharing a queue push port among NUM_REQ
//               valid/ready producers. A grant lasts up to BURST_LEN accepted
//               words; pushes are withheld while the queue is full or popping.
// Revision    : 1.0 - initial release
// ============================================================================
module queue_wr_arbiter
    import queue_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  data_t                      i_req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic                       i_q_full,
    input  logic                       i_q_pop,
    output logic                       o_q_we,
    output data_t                      o_q_wr_data,
    output logic                       o_grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

    localparam int c_IDW = $clog2(NUM_REQ);
    localparam int c_CW  = $clog2(BURST_LEN + 1);
    localparam logic [c_CW-1:0]  c_LAST  = c_CW'(BURST_LEN - 1);
    localparam logic [c_IDW-1:0] c_MAXID = c_IDW'(NUM_REQ - 1);

    arb_state_t       r_state;
    logic             r_grant_valid;
    logic [c_IDW-1:0] r_grant_id;
    logic [c_IDW-1:0] r_rr_ptr;
    logic [c_CW-1:0]  r_cnt;

    logic             w_busy;
    logic             w_held_valid;
    logic             w_open;
    logic             w_beat;
    logic             w_last;
    logic             w_release;
    logic [c_IDW-1:0] w_next_g;
    logic [c_IDW-1:0] w_start;
    logic             w_found;
    logic [c_IDW-1:0] w_pick;

    assign w_busy       = (r_state == ARB_BUSY);
    assign w_held_valid = i_req_valid[r_grant_id];
    // The queue drops a push in any cycle it pops, so popping closes the port.
    assign w_open       = ~i_q_full & ~i_q_pop;
    assign w_beat       = w_busy & w_held_valid & w_open;
    assign w_last       = w_beat & (r_cnt == c_LAST);
    assign w_release    = w_busy & (w_last | ~w_held_valid);
    assign w_next_g     = (r_grant_id == c_MAXID) ? '0 : r_grant_id + 1'b1;
    // On release the search starts just after the holder, making the holder
    // the lowest-priority candidate; from IDLE it starts at the saved pointer.
    assign w_start      = w_busy ? w_next_g : r_rr_ptr;

    queue_wr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (c_IDW)
    ) u_rr_pick (
        .i_req   (i_req_valid),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // Only the grant holder sees ready, and only while the queue can take it.
    always_comb begin
        o_req_ready = '0;
        if (w_busy && w_open) begin
            o_req_ready[r_grant_id] = 1'b1;
        end
    end

    assign o_q_we        = w_beat;
    assign o_q_wr_data   = i_req_data[r_grant_id];
    assign o_grant_valid = r_grant_valid;
    assign o_grant_id    = r_grant_id;

    // Grant state machine: acquire from IDLE, count beats, hand off on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ARB_IDLE;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_state       <= ARB_BUSY;
                        r_grant_valid <= 1'b1;
                        r_grant_id    <= w_pick;
                        r_cnt         <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (w_release) begin
                        r_rr_ptr <= w_next_g;
                        r_cnt    <= '0;
                        if (w_found) begin
                            r_grant_id <= w_pick;
                        end else begin
                            r_state       <= ARB_IDLE;
                            r_grant_valid <= 1'b0;
                        end
                    end else if (w_beat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state       <= ARB_IDLE;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : queue_wr_arbiter
`default_nettype wire

// File: tb/tb_queue_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_queue_wr_arbiter
// Description : Self-checking bench for queue_wr_arbiter with directed
//               scenarios and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_wr_arbiter;
    import queue_wr_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int BL = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] valid = '0;
    data_t        data [N];
    logic         full = 1'b0;
    logic         pop = 1'b0;
    logic [N-1:0] ready;
    logic         q_we;
    data_t        q_wr_data;
    logic         grant_valid;
    logic [1:0]   grant_id;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state: holder flag, holder index, words in this grant,
    // next search start, and which producer (if any) was accepted last edge.
    int m_hold = 0;
    int m_g    = 0;
    int m_cnt  = 0;
    int m_ptr  = 0;
    int m_acc  = -1;
    int seq [N];

    queue_wr_arbiter #(
        .NUM_REQ   (N),
        .BURST_LEN (BL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (valid),
        .i_req_data    (data),
        .o_req_ready   (ready),
        .i_q_full      (full),
        .i_q_pop       (pop),
        .o_q_we        (q_we),
        .o_q_wr_data   (q_wr_data),
        .o_grant_valid (grant_valid),
        .o_grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    function automatic data_t mk(int p, int s);
        return data_t'((p << 12) | (s & 12'hfff));
    endfunction

    // First valid producer at or after start, wrapping; -1 if none.
    function automatic int search(int start);
        for (int k = 0; k < N; k++) begin
            if (valid[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Apply the arbitration rules to the current inputs, advance one clock,
    // then give the accepted producer its next word.
    task automatic model_clock();
        int  w;
        bit  beat;
        m_acc = -1;
        if (!rst_n) begin
            m_hold = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
        end else if (m_hold == 0) begin
            w = search(m_ptr);
            if (w >= 0) begin
                m_hold = 1; m_g = w; m_cnt = 0;
            end
        end else begin
            beat = valid[m_g] && !full && !pop;
            if (beat) begin
                m_acc = m_g;
                m_cnt++;
            end
            if ((beat && m_cnt == BL) || !valid[m_g]) begin
                m_ptr = (m_g + 1) % N;
                w = search(m_ptr);
                if (w >= 0) begin
                    m_g = w; m_cnt = 0;
                end else begin
                    m_hold = 0; m_cnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (m_acc >= 0) begin
            seq[m_acc]++;
            data[m_acc] = mk(m_acc, seq[m_acc]);
        end
    endtask

    task automatic do_reset(input logic [N-1:0] v);
        rst_n = 1'b0;
        full  = 1'b0;
        pop   = 1'b0;
        valid = v;
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            data[i] = mk(i, 0);
        end
        model_clock();
        model_clock();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset('1);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (grant_valid !== 1'b0 || q_we !== 1'b0 || ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: grant_valid=%b q_we=%b ready=%b, want 0 0 0000",
                     grant_valid, q_we, ready);
        end
        model_clock();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: grant_valid=%b want 0", grant_valid);
        end
        model_clock();
        vectors++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant: grant_valid=%b grant_id=%0d want 1 0",
                     grant_valid, grant_id);
        end
    endtask

    task automatic test_fair_rotation();
        int words = 0;
        do_reset('1);
        for (int c = 0; c < 17; c++) begin
            #1;
            vectors++;
            if (q_we !== (c != 0)) begin
                errors++;
                $display("FAIL rot_we c=%0d: q_we=%b want %b", c, q_we, c != 0);
            end
            if (c > 0) begin
                vectors++;
                if (grant_id !== 2'((c - 1) / 4) || q_wr_data !== mk((c - 1) / 4, (c - 1) % 4)) begin
                    errors++;
                    $display("FAIL rot_id c=%0d: id=%0d data=%h want %0d %h", c, grant_id,
                             q_wr_data, (c - 1) / 4, mk((c - 1) / 4, (c - 1) % 4));
                end
            end
            if (q_we === 1'b1) words++;
            model_clock();
        end
        vectors++;
        if (words != 16) begin
            errors++;
            $display("FAIL rot_count: words=%0d want 16", words);
        end
    endtask

    task automatic test_early_release();
        bit exp_we [9] = '{0, 1, 1, 0, 1, 1, 1, 1, 1};
        int exp_id [9] = '{0, 2, 2, 2, 3, 3, 3, 3, 2};
        do_reset(4'b1100);
        for (int c = 0; c < 9; c++) begin
            valid[2] = (c != 3);
            #1;
            vectors++;
            if (q_we !== exp_we[c] || (c > 0 && (grant_valid !== 1'b1 || grant_id !== 2'(exp_id[c])))) begin
                errors++;
                $display("FAIL early c=%0d: we=%b gv=%b id=%0d want we=%b gv=1 id=%0d",
                         c, q_we, grant_valid, grant_id, exp_we[c], exp_id[c]);
            end
            model_clock();
        end
    endtask

    task automatic test_stall();
        int p1_words = 0;
        do_reset(4'b0010);
        for (int c = 0; c < 10; c++) begin
            full = (c >= 1 && c <= 3);
            pop  = (c == 4);
            if (c >= 2) valid[0] = 1'b1;
            #1;
            if (c >= 1 && c <= 4) begin
                vectors++;
                if (ready !== 4'b0000 || q_we !== 1'b0 || grant_id !== 2'd1) begin
                    errors++;
                    $display("FAIL stall c=%0d: ready=%b we=%b id=%0d want 0000 0 1",
                             c, ready, q_we, grant_id);
                end
            end
            if (c >= 5 && c <= 8) begin
                vectors++;
                if (q_we !== 1'b1 || grant_id !== 2'd1 || ready !== 4'b0010) begin
                    errors++;
                    $display("FAIL stall_resume c=%0d: we=%b id=%0d ready=%b want 1 1 0010",
                             c, q_we, grant_id, ready);
                end
            end
            if (q_we === 1'b1 && grant_id === 2'd1) p1_words++;
            if (c == 9) begin
                vectors++;
                if (grant_id !== 2'd0 || p1_words != 4) begin
                    errors++;
                    $display("FAIL stall_burst: id=%0d words=%0d want 0 4", grant_id, p1_words);
                end
            end
            model_clock();
        end
        full = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic test_sole_requester();
        int sent = 0;
        do_reset(4'b1000);
        for (int c = 0; c < 11; c++) begin
            #1;
            vectors++;
            if (q_we !== (c != 0)) begin
                errors++;
                $display("FAIL sole_we c=%0d: we=%b want %b", c, q_we, c != 0);
            end
            if (c > 0) begin
                vectors++;
                if (grant_id !== 2'd3 || q_wr_data !== mk(3, sent)) begin
                    errors++;
                    $display("FAIL sole_data c=%0d: id=%0d data=%h want 3 %h",
                             c, grant_id, q_wr_data, mk(3, sent));
                end
                sent++;
            end
            model_clock();
        end
    endtask

    task automatic test_mid_reset();
        do_reset('1);
        for (int c = 0; c < 7; c++) model_clock();
        // Two words of producer 1 accepted; drop reset mid-cycle.
        #2;
        rst_n = 1'b0;
        m_hold = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
        #1;
        vectors++;
        if (q_we !== 1'b0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drop: we=%b gv=%b want 0 0", q_we, grant_valid);
        end
        model_clock();
        rst_n = 1'b1;
        model_clock();
        #1;
        vectors++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0 || q_we !== 1'b1) begin
            errors++;
            $display("FAIL midreset_restart: gv=%b id=%0d we=%b want 1 0 1",
                     grant_valid, grant_id, q_we);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        bit           ew;
        do_reset('0);
        for (int c = 0; c < 600; c++) begin
            if (m_acc >= 0) valid[m_acc] = ($urandom_range(0, 99) < 60);
            for (int i = 0; i < N; i++) begin
                if (!valid[i]) valid[i] = ($urandom_range(0, 99) < 35);
            end
            full = ($urandom_range(0, 99) < 20);
            pop  = ($urandom_range(0, 99) < 15);
            #1;
            ew = (m_hold != 0) && valid[m_g] && !full && !pop;
            er = '0;
            if (m_hold != 0 && !full && !pop) er[m_g] = 1'b1;
            vectors++;
            if (grant_valid !== (m_hold != 0) || q_we !== ew || ready !== er
                || (m_hold != 0 && grant_id !== 2'(m_g))
                || (ew && q_wr_data !== data[m_g])) begin
                errors++;
                $display("FAIL random c=%0d: gv=%b id=%0d we=%b rdy=%b d=%h want gv=%0d id=%0d we=%b rdy=%b d=%h",
                         c, grant_valid, grant_id, q_we, ready, q_wr_data,
                         m_hold, m_g, ew, er, data[m_g]);
            end
            model_clock();
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            data[i] = mk(i, 0);
        end
        test_reset();
        test_fair_rotation();
        test_early_release();
        test_stall();
        test_sole_requester();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_queue_wr_arbiter
`default_nettype wire

// File: doc/queue_wr_arbiter.md
# queue_wr_arbiter

Round-robin write-side arbiter that lets NUM_REQ independent producers share the single push port of a `queue` instance. Each producer presents a valid/ready stream of `data_t` words. The arbiter grants one producer at a time for a bounded burst and forwards its words to the queue's `we`/`wr_data`. It withholds pushes whenever the queue is full or is being popped in the same cycle, so no accepted word is ever lost.

## Interface
- NUM_REQ, 4, number of producers (2..16)
- BURST_LEN, 4, max consecutive accepted words per grant before rotation (1..255)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately on assertion
- req_valid  in  NUM_REQ  per-producer word available
- req_data  in  NUM_REQ x data_t  per-producer word
- req_ready  out  NUM_REQ  per-producer word accepted this cycle when paired with valid
- q_full  in  1  queue full flag
- q_pop  in  1  consumer asserts queue `re` this cycle with queue non-empty
- q_we  out  1  queue push strobe
- q_wr_data  out  data_t  queue push data
- grant_valid  out  1  a producer currently holds the grant
- grant_id  out  $clog2(NUM_REQ)  index of grant holder

## Operation
- State machine, two states:
  - IDLE: no grant held.
  - BUSY: grant held by grant_id; burst counter tracks words accepted.
- IDLE -> BUSY when any req_valid is high.
  - Winner is chosen by round-robin from rr_ptr.
  - grant_id, grant_valid and burst counter = 0 are registered at that edge. No word transfers in the IDLE cycle.
- In BUSY, with g = grant_id, req_ready[g] = ~q_full & ~q_pop. All other req_ready bits are 0.
- Transfer ("beat") = req_valid[g] & req_ready[g].
  - q_we = beat, q_wr_data = req_data[g].
  - Pushes are withheld on q_pop because the queue ignores a push in any cycle it pops.
- Burst counter increments on each beat.
- Release of the grant occurs at the edge where either:
  - a beat brings the counter to BURST_LEN, or
  - req_valid[g] is low.
- On release:
  - rr_ptr <= g+1 mod NUM_REQ.
  - The next winner is picked in the same cycle from req_valid, searching from g+1 with g lowest priority, and loaded directly (BUSY -> BUSY, counter cleared).
  - If no requester is valid, go to IDLE.
  - If only g is valid after a completed burst, g is re-granted with a fresh counter.
- Stall (q_full or q_pop high) does not advance the counter and does not cause release while req_valid[g] stays high.
- Producers must hold req_valid/req_data stable until accepted. The arbiter does not check this.

## Timing
- Reset values:
  - state IDLE, grant_valid 0, grant_id 0, burst counter 0, rr_ptr 0.
  - Hence q_we 0, req_ready all 0; q_wr_data don't-care, driven from req_data[0].
- Latency:
  - A first request from IDLE is accepted at the earliest one cycle after req_valid rises.
  - Back-to-back grant handoff costs zero cycles.
- Throughput: one word per cycle while the grant holder is valid and the queue is neither full nor popping.
- Reset asserted mid-burst: grant dropped immediately. Words already pushed remain in the queue (the queue's own reset clears them if shared).
- Counter width: $clog2(BURST_LEN+1) bits. Wrap is never reached because release occurs at BURST_LEN.

## Structure
- `defines.sv`: `data_t` (existing) and the arbiter state enum `arb_state_t` {ARB_IDLE, ARB_BUSY}.
- Sub-module `rr_pick`, combinational:
  - Inputs: NUM_REQ request vector, start index.
  - Outputs: found flag, winner index.
  - Implementation: double-width rotate-and-priority-encode.
  - Used once in the arbiter.

## Test plan
NUM_REQ=4, BURST_LEN=4 throughout.
- Reset check: hold reset low with all req_valid=1 → grant_valid=0, q_we=0, req_ready=0000. Release reset → grant_valid=1, grant_id=0 one cycle later.
- Fair rotation: all four producers continuously valid, queue never full → q_we high every cycle after the first grant; grant_id sequence 0,0,0,0,1,1,1,1,2,…; 16 words in 17 cycles.
- Early release: producer 2 alone sends 2 words then drops valid, producer 3 valid → grant passes to 3 with no idle cycle; producer 2's counter does not carry over.
- Full/pop stall: grant to 1, q_full=1 for 3 cycles → req_ready[1]=0, q_we=0, burst counter unchanged. q_pop=1 with q_full=0 → q_we=0. After both clear, exactly 4 words from producer 1 are pushed.
- Sole requester: only producer 3 valid for 10 words → q_we every cycle after the first grant. Grant re-issued to 3 at each burst boundary with no gap; pushed data order matches send order.
- Mid-burst reset: reset asserted after 2 words of a grant → q_we falls the same cycle. After deassertion, arbitration restarts from rr_ptr=0.
